pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter and instruction-fetch front end of the RISC-V core.
//  Issues one-outstanding fetch requests to instruction memory and presents fetched words to decode.
//  Consumes the branch decision (branch, from the ALU BEQ/BNE/BLT/BGE/BLTU/BGEU ops) and jump targets to redirect the PC.
//  Discards wrong-path responses and signals a pipeline flush.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1     core clock, all state on rising edge
//  reset_n        in   1     asynchronous, active-low reset
//  stall          in   1     decode cannot accept; hold the instr output
//  branch_valid   in   1     a conditional branch resolved this cycle
//  branch         in   1     ALU branch decision (1 = taken)
//  branch_target  in   XLEN  taken-branch target
//  jump           in   1     JAL/JALR redirect this cycle
//  jump_target    in   XLEN  jump target
//  imem_req       out  1     fetch request valid
//  imem_addr      out  XLEN  fetch address, word aligned
//  imem_ready     in   1     memory accepts the request this cycle
//  imem_rvalid    in   1     response data valid (>=1 cycle after acceptance)
//  imem_rdata     in   XLEN  instruction word
//  instr_valid    out  1     instr/instr_pc hold a valid fetched instruction
//  instr          out  XLEN  fetched instruction
//  instr_pc       out  XLEN  address of instr
//  flush          out  1     one-cycle pulse: younger pipeline stages must be killed
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, flush=0.
//  redirect = (branch_valid & branch) | jump; next target = branch target if both fire (older instr wins), else jump_target.
//  Target bits [1:0] are forced to 0.
//  States:
//   IDLE  -> FETCH on the first edge after reset release.
//   FETCH -> imem_req=1, imem_addr=req_addr. Requests are raised only if !instr_valid | !stall.
//            On imem_req & imem_ready: go to WAIT (or to DROP if a redirect was sampled while the request was pending).
//   WAIT  -> on imem_rvalid: instr<=rdata, instr_pc<=req_addr, instr_valid<=1, pc<=pc+4, go to FETCH.
//   DROP  -> on imem_rvalid: discard data, go to FETCH at the redirected pc.
//  Request handshake: while imem_req=1 and !imem_ready, imem_addr and imem_req stay stable; a redirect never retracts a request.
//  Redirect sampled in any state:
//   pc <= target; instr_valid <= 0; flush=1 on the following cycle only.
//   WAIT goes to DROP; accepted-but-pending FETCH goes to DROP; unissued FETCH refetches from the target.
//  Redirect together with imem_rvalid in WAIT: the response is discarded, go to FETCH at the target.
//  Output hold: instr_valid & stall keeps instr/instr_pc/instr_valid unchanged; no new request is issued. At most one outstanding request.
//  Latency:
//   first imem_req in the 2nd cycle after reset release;
//   rvalid to instr_valid is 1 cycle;
//   redirect to imem_req at the target is <=1 cycle when no response is outstanding.
//  PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
//  Reset asserted mid-transaction: everything returns to reset values immediately; a late rvalid after reset is ignored (state IDLE/FETCH without an outstanding request).
// STRUCTURE
//  Shared package riscv_pkg: XLEN, RESET_PC default, fetch state enum (IDLE/FETCH/WAIT/DROP).
//  Sub-module pc_redirect_sel (combinational target priority + alignment); the rest is a single FSM.
// TESTING
//  1 Reset release, imem_ready=1, rvalid 1 cycle later -> addrs 0,4,8; instr_pc tracks; instr_valid per word.
//  2 imem_ready held 0 for 3 cycles -> imem_addr stable at 0x8, no duplicate request.
//  3 Taken branch to 0x100 while WAIT on 0x10 -> flush pulse; 0x10 data dropped; next instr_pc=0x100.
//  4 branch_valid&branch (0x200) with jump (0x300) same cycle -> fetch resumes at 0x200.
//  5 stall=1 for 4 cycles with instr_valid -> outputs frozen, imem_req=0; resumes at pc+4 after release.
//  6 reset_n low while WAIT, then stray rvalid -> no instr_valid; fetch restarts at RESET_PC; 0xFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: data width, reset
// vector and the fetch FSM state encoding.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // IDLE:  one cycle after reset release, nothing issued
    // FETCH: request may be raised / is being held for imem_ready
    // WAIT:  one request accepted, its response will be delivered
    // DROP:  one request accepted, its response is wrong-path and discarded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_redirect_sel.sv
// Redirect detection and target selection. A taken conditional branch
// belongs to an older instruction than a same-cycle jump, so it wins.
// The selected target is forced to word alignment.
module pc_redirect_sel #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            branch_valid,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect,
    output logic [XLEN-1:0] target
);

    // Priority mux: taken branch over jump, then clear the byte offset
    always_comb begin
        redirect    = (branch_valid & branch) | jump;
        target      = (branch_valid & branch) ? branch_target : jump_target;
        target[1:0] = 2'b00;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch front end. Keeps at most one
// request outstanding to instruction memory, presents fetched words to
// decode and drops wrong-path responses after a branch/jump redirect.
//
// Handshakes: a request transfers on a rising edge where imem_req and
// imem_ready are both 1; once raised, imem_req and imem_addr stay stable
// until that edge (a redirect never retracts it). imem_rvalid has no
// backpressure. Toward decode, instr is consumed on an edge where
// instr_valid=1 and stall=0; with stall=1 it is held unchanged.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            flush,
    output fetch_state_e    dbg_state
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;              // next address to fetch
    logic [XLEN-1:0] req_addr_q, req_addr_d;  // address of the last issued request
    logic            req_hold_q, req_hold_d;  // request raised, not yet accepted
    logic            redir_pend_q, redir_pend_d; // redirect seen while request held
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            flush_q, flush_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            accept;

    pc_redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
        .branch_valid  (branch_valid),
        .branch        (branch),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .redirect      (redirect),
        .target        (target)
    );

    // State register: FSM state and all datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            req_hold_q    <= 1'b0;
            redir_pend_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            req_hold_q    <= req_hold_d;
            redir_pend_q  <= redir_pend_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            flush_q       <= flush_d;
        end
    end

    // Next-state logic: transitions, response capture and redirect handling
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = imem_req ? imem_addr : req_addr_q;
        req_hold_d    = imem_req & ~imem_ready;
        redir_pend_d  = redir_pend_q;
        instr_valid_d = instr_valid_q & stall;  // cleared once decode consumes it
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        flush_d       = redirect;
        accept        = imem_req & imem_ready;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (accept) begin
                    // Accepted request is wrong-path if a redirect arrived while it was up
                    state_d      = (redir_pend_q | redirect) ? DROP : WAIT;
                    redir_pend_d = 1'b0;
                end else if (imem_req && redirect) begin
                    redir_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                    if (!redirect) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_addr_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(4);
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d          = target;
            instr_valid_d = 1'b0;
        end
    end

    // Output logic: request generation and registered outputs
    always_comb begin
        imem_req    = (state_q == FETCH) & (req_hold_q | ~instr_valid_q | ~stall);
        imem_addr   = req_hold_q ? req_addr_q : pc_q;
        instr_valid = instr_valid_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
        flush       = flush_q;
        dbg_state   = state_q;
    end

endmodule
